mem_copy_engine: RTL and testbench
==================================

Name: mem_copy_engine

Overview:
- Memory-side initiator: autonomously copies a block of 16-bit words from a source region to a destination region of the single-port data memory.
- Drives the memory's MemRead/MemWrite/MemIn/WriteData and consumes MemOut.
- Sits beside the multi-cycle datapath and is started by a control-unit pulse; the memory-port mux is external to this block.

Parameters:
- DATA_W, 16, memory word width
- ADDR_W, 16, memory address width; pointers wrap modulo 2^ADDR_W
- LEN_W, 8, width of the word-count input

Ports:
- clock  in  1  sole clock; all state changes on the posedge
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- src_addr  in  ADDR_W  first source word address, latched at start
- dst_addr  in  ADDR_W  first destination word address, latched at start
- length  in  LEN_W  number of words to copy, latched at start
- fill  in  1  fill-mode select (see Optional Feature)
- fill_value  in  DATA_W  fill word (see Optional Feature)
- busy  out  1  high in READ, WAIT and WRITE
- done  out  1  one-cycle completion pulse
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- MemIn  out  ADDR_W  memory address
- WriteData  out  DATA_W  memory write data
- MemOut  in  DATA_W  memory read data; valid the cycle after the edge that sampled MemRead=1

Behaviour:
- Reset (async): state IDLE; busy, done, MemRead, MemWrite = 0; MemIn, WriteData, internal pointers, count and data_q = 0.
- All outputs are decoded from registers only; there is no combinational path from any input to any output.
- IDLE:
  - start=1 and length!=0: latch src_ptr, dst_ptr, count; go to READ.
  - start=1 and length==0: go to DONE with no memory access.
  - Otherwise: hold IDLE.
- READ: MemRead=1, MemIn=src_ptr; go to WAIT.
- WAIT: all strobes 0, MemIn holds src_ptr; data_q <= MemOut at end of cycle; go to WRITE.
- WRITE: MemWrite=1, MemIn=dst_ptr, WriteData=data_q.
  - At end of cycle: src_ptr++, dst_ptr++, count--.
  - If count was 1, go to DONE; otherwise go to READ.
- DONE: done=1 and busy=0 for exactly one cycle; then IDLE.
- Throughput: 3 cycles per word. For N>0, start sampled at edge k gives done high in cycle k+3N+1.
- start while not in IDLE is ignored and not queued.
- MemRead and MemWrite are never high in the same cycle.
- Pointer increment wraps 0xFFFF -> 0x0000 with no error.
- Overlapping regions are copied strictly forward, word by word, in ascending order. If dst lies inside (src, src+N), the copy propagates; this is the defined behaviour.
- Reset mid-copy: the block aborts immediately and issues no further strobes. Writes already committed remain; no done pulse is produced.

Optional Feature:
- Macro: MEM_COPY_FILL_EN.
- Defined: start with fill=1 latches fill_value into data_q and enters WRITE directly.
  - Each following word is WRITE only (1 cycle/word); READ and WAIT are skipped.
  - N>0 gives done in cycle k+N+1.
  - fill=0 behaves as a normal copy.
- Undefined: fill and fill_value are ignored and every request is a copy.

Decomposition:
- Shared package mem_copy_pkg holds:
  - state encoding constants IDLE, READ, WAIT, WRITE, DONE (3-bit)
  - DATA_W and ADDR_W defaults
- One natural sub-module: mem_copy_addr_ctr (loadable ADDR_W incrementer), instantiated twice for src_ptr and dst_ptr.
- The count decrementer and FSM stay in the top module.

Test Plan:
- Bench memory model: 256x16 array, 1-cycle registered read, write on posedge.
- Copy basic: mem[0x10..0x13]={0xA1,0xB2,0xC3,0xD4}, src=0x10, dst=0x40, length=4 -> mem[0x40..0x43] matches; done exactly 13 cycles after start; MemWrite high 4 times.
- Zero length: length=0, start -> done pulses the next cycle; MemRead and MemWrite never asserted; busy stays 0.
- Overlap forward: mem[0x20]=0x1111, mem[0x21]=0x2222, src=0x20, dst=0x21, length=3 -> mem[0x21..0x23] all 0x1111.
- Wrap and ignored start: src=0xFFFF, dst=0x0100, length=2 -> second read at MemIn=0x0000; a start pulse mid-copy changes nothing.
- Reset mid-copy: reset asserted in the WAIT state of word 2 of 4 -> all outputs 0 the same cycle; only word 1 written; no done pulse; a subsequent copy works normally.
- Fill (MEM_COPY_FILL_EN defined): fill=1, fill_value=0xBEEF, dst=0x80, length=5 -> mem[0x80..0x84]=0xBEEF; MemRead never asserted; done 6 cycles after start.

Source files
------------

// File: rtl/mem_copy_pkg.sv
// mem_copy_pkg: shared widths and FSM state encoding for the copy engine.
// Imported by the interface, the address counter and the top module.
package mem_copy_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_LEN_W  = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/mem_copy_engine_if.sv
// mem_copy_engine_if: single-port data memory bus.
// master: MemRead/MemWrite/MemIn/WriteData out, MemOut in; slave: mirror.
interface mem_copy_engine_if
  import mem_copy_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] MemIn;
  logic [DATA_W-1:0] WriteData;
  logic [DATA_W-1:0] MemOut;

  modport master (
    output MemRead,
    output MemWrite,
    output MemIn,
    output WriteData,
    input  MemOut
  );

  modport slave (
    input  MemRead,
    input  MemWrite,
    input  MemIn,
    input  WriteData,
    output MemOut
  );

endinterface

// File: rtl/mem_copy_addr_ctr.sv
// mem_copy_addr_ctr: loadable address incrementer, wraps modulo 2^ADDR_W.
// Ports: clock, reset, load/loadValue, step, value.
module mem_copy_addr_ctr
  import mem_copy_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] loadValue,
  output logic [ADDR_W-1:0] value
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= loadValue;
    end else if (step) begin
      value <= value + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: copies length words src_addr.. -> dst_addr.. forward.
// Ports: clock, reset, start/src_addr/dst_addr/length/fill/fill_value,
// busy/done status, mem (master side of the data memory bus).
// Optional fill mode is compiled in with `define MEM_COPY_FILL_EN.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_value,
  output logic              busy,
  output logic              done,
  mem_copy_engine_if.master mem
);

  state_t state;
  state_t stateNext;

  logic              loadPtrs;
  logic              stepPtrs;
  logic              startFill;
  logic              fillMode;
  logic [ADDR_W-1:0] srcPtr;
  logic [ADDR_W-1:0] dstPtr;
  logic [LEN_W-1:0]  count;
  logic [DATA_W-1:0] data_q;

`ifdef MEM_COPY_FILL_EN
  assign startFill = fill;

  // Remembers whether the running request skips READ/WAIT.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fillMode <= 1'b0;
    end else if (loadPtrs) begin
      fillMode <= startFill;
    end
  end
`else
  logic unusedFill;
  assign unusedFill = fill;
  assign startFill  = 1'b0;
  assign fillMode   = 1'b0;
`endif

  mem_copy_addr_ctr #(
    .ADDR_W(ADDR_W)
  ) uSrcCtr (
    .clock     (clock),
    .reset     (reset),
    .load      (loadPtrs),
    .step      (stepPtrs),
    .loadValue (src_addr),
    .value     (srcPtr)
  );

  mem_copy_addr_ctr #(
    .ADDR_W(ADDR_W)
  ) uDstCtr (
    .clock     (clock),
    .reset     (reset),
    .load      (loadPtrs),
    .step      (stepPtrs),
    .loadValue (dst_addr),
    .value     (dstPtr)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    loadPtrs  = 1'b0;
    stepPtrs  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (length == '0) begin
            stateNext = DONE;
          end else begin
            loadPtrs  = 1'b1;
            stateNext = startFill ? WRITE : READ;
          end
        end
      end
      READ:  stateNext = WAIT;
      WAIT:  stateNext = WRITE;
      WRITE: begin
        stepPtrs = 1'b1;
        if (count == LEN_W'(1)) begin
          stateNext = DONE;
        end else if (fillMode) begin
          stateNext = WRITE;
        end else begin
          stateNext = READ;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (loadPtrs) begin
      count <= length;
    end else if (stepPtrs) begin
      count <= count - LEN_W'(1);
    end
  end

  // Fill word is captured at start; copy data at the end of WAIT.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else if (loadPtrs && startFill) begin
      data_q <= fill_value;
    end else if (state == WAIT) begin
      data_q <= mem.MemOut;
    end
  end

  // Outputs decode the state and datapath registers only.
  assign busy          = (state == READ) ||
                         (state == WAIT) ||
                         (state == WRITE);
  assign done          = (state == DONE);
  assign mem.MemRead   = (state == READ);
  assign mem.MemWrite  = (state == WRITE);
  assign mem.MemIn     = (state == WRITE) ? dstPtr : srcPtr;
  assign mem.WriteData = data_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: bench for mem_copy_engine with a 256x16 memory
// and a word-array reference model; honours MEM_COPY_FILL_EN.
module tb_mem_copy_engine;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [7:0]  length;
  logic        fill;
  logic [15:0] fill_value;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  mem_copy_engine_if memBus ();

  mem_copy_engine dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .length     (length),
    .fill       (fill),
    .fill_value (fill_value),
    .busy       (busy),
    .done       (done),
    .mem        (memBus)
  );

  logic [15:0] memArr [256];
  logic [15:0] refMem [256];
  logic [15:0] rdData;
  logic        pokeEn = 1'b0;
  logic [7:0]  pokeAddr = 8'd0;
  logic [15:0] pokeData = 16'd0;
  logic [15:0] rdAddrs [$];

  always @(posedge clock) begin
    if (pokeEn) begin
      memArr[pokeAddr] <= pokeData;
    end else if (memBus.MemWrite) begin
      memArr[memBus.MemIn[7:0]] <= memBus.WriteData;
    end
    if (memBus.MemRead) begin
      rdData <= memArr[memBus.MemIn[7:0]];
    end
  end

  assign memBus.MemOut = rdData;

  typedef struct {
    string       tag;
    logic [15:0] src;
    logic [15:0] dst;
    logic [7:0]  len;
    int          expCycles;
    int          expReads;
    int          expWrites;
  } vec_t;

  vec_t vecs [3];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [15:0] d);
    @(negedge clock);
    pokeEn   = 1'b1;
    pokeAddr = a;
    pokeData = d;
    refMem[a] = d;
    @(posedge clock);
    #1 pokeEn = 1'b0;
  endtask

  task automatic checkMem(input string name);
    int bad;
    bad = -1;
    for (int i = 0; i < 256; i++) begin
      if (bad < 0 && memArr[i] !== refMem[i]) bad = i;
    end
    if (bad < 0) begin
      check(name, 32'd0, 32'd0 + 0);
    end else begin
      checks++;
      failures++;
      $display("FAIL %s addr=%h actual=%h required=%h",
               name, bad[7:0], memArr[bad], refMem[bad]);
    end
  endtask

  // Reference: forward word-by-word copy or fill, 8-bit aliased memory.
  task automatic modelCopy(input logic [15:0] s, input logic [15:0] d,
                           input int n, input logic f,
                           input logic [15:0] fv);
    for (int i = 0; i < n; i++) begin
      logic [7:0] sa;
      logic [7:0] da;
      sa = 8'(s + 16'(i));
      da = 8'(d + 16'(i));
      refMem[da] = f ? fv : refMem[sa];
    end
  endtask

  task automatic doCopy(input string tag,
                        input logic [15:0] s, input logic [15:0] d,
                        input logic [7:0] n, input logic f,
                        input logic [15:0] fv, input int pokeAt,
                        input int expCycles, input int expReads,
                        input int expWrites, input logic fillEff);
    int cyc, nRd, nWr, nBoth, nBusy;
    bit seen;
    cyc = 0; nRd = 0; nWr = 0; nBoth = 0; nBusy = 0; seen = 0;
    rdAddrs.delete();
    @(negedge clock);
    src_addr = s; dst_addr = d; length = n;
    fill = f; fill_value = fv; start = 1'b1;
    while (!seen && cyc < 1000) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (pokeAt != 0 && cyc == pokeAt) begin
        start = 1'b1; src_addr = 16'h0000;
        dst_addr = 16'h0000; length = 8'd9;
      end
      if (pokeAt != 0 && cyc == pokeAt + 1) start = 1'b0;
      if (memBus.MemRead) begin
        nRd++;
        rdAddrs.push_back(memBus.MemIn);
      end
      if (memBus.MemWrite) nWr++;
      if (memBus.MemRead && memBus.MemWrite) nBoth++;
      if (busy) nBusy++;
      if (done) seen = 1;
    end
    check({tag, " timeout"}, 32'(seen), 32'd1);
    check({tag, " cycles"}, cyc, expCycles);
    check({tag, " reads"}, nRd, expReads);
    check({tag, " writes"}, nWr, expWrites);
    check({tag, " rd_and_wr"}, nBoth, 0);
    check({tag, " busy_cycles"}, nBusy, expCycles - 1);
    @(negedge clock);
    check({tag, " done_pulse_width"}, 32'(done), 0);
    check({tag, " idle_after"}, 32'(busy), 0);
    modelCopy(s, d, int'(n), fillEff, fv);
    checkMem({tag, " mem"});
  endtask

  initial begin
    logic fe;
    reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0;
    length = '0; fill = 1'b0; fill_value = '0;
`ifdef MEM_COPY_FILL_EN
    fe = 1'b1;
`else
    fe = 1'b0;
`endif
    #1;
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset strobes",
          {30'd0, memBus.MemRead, memBus.MemWrite}, 0);
    check("reset MemIn", 32'(memBus.MemIn), 0);
    check("reset WriteData", 32'(memBus.WriteData), 0);
    for (int i = 0; i < 256; i++) poke(8'(i), 16'($urandom));
    @(negedge clock);
    reset = 1'b0;

    poke(8'h10, 16'h00A1); poke(8'h11, 16'h00B2);
    poke(8'h12, 16'h00C3); poke(8'h13, 16'h00D4);
    poke(8'h20, 16'h1111); poke(8'h21, 16'h2222);

    vecs[0] = '{"basic",   16'h0010, 16'h0040, 8'd4, 13, 4, 4};
    vecs[1] = '{"overlap", 16'h0020, 16'h0021, 8'd3, 10, 3, 3};
    vecs[2] = '{"zero",    16'h0030, 16'h0050, 8'd0, 1, 0, 0};
    for (int v = 0; v < 3; v++) begin
      doCopy(vecs[v].tag, vecs[v].src, vecs[v].dst, vecs[v].len,
             1'b0, 16'h0, 0, vecs[v].expCycles,
             vecs[v].expReads, vecs[v].expWrites, 1'b0);
    end
    check("basic w0", 32'(memArr[8'h40]), 32'h00A1);
    check("basic w1", 32'(memArr[8'h41]), 32'h00B2);
    check("basic w2", 32'(memArr[8'h42]), 32'h00C3);
    check("basic w3", 32'(memArr[8'h43]), 32'h00D4);
    check("overlap w0", 32'(memArr[8'h21]), 32'h1111);
    check("overlap w1", 32'(memArr[8'h22]), 32'h1111);
    check("overlap w2", 32'(memArr[8'h23]), 32'h1111);

    doCopy("wrap", 16'hFFFF, 16'h0100, 8'd2, 1'b0, 16'h0, 3,
           7, 2, 2, 1'b0);
    check("wrap rd count", rdAddrs.size(), 2);
    if (rdAddrs.size() == 2) begin
      check("wrap rd0", 32'(rdAddrs[0]), 32'h0000FFFF);
      check("wrap rd1", 32'(rdAddrs[1]), 32'h00000000);
    end

    begin
      int cyc, nDone, nBusy;
      cyc = 0; nDone = 0; nBusy = 0;
      @(negedge clock);
      src_addr = 16'h0050; dst_addr = 16'h0060; length = 8'd4;
      fill = 1'b0; start = 1'b1;
      while (cyc < 5) begin
        @(negedge clock);
        cyc++;
        if (cyc == 1) start = 1'b0;
      end
      check("rst wait busy", 32'(busy), 1);
      check("rst wait strobes",
            {30'd0, memBus.MemRead, memBus.MemWrite}, 0);
      reset = 1'b1;
      #1;
      check("rst busy", 32'(busy), 0);
      check("rst done", 32'(done), 0);
      check("rst strobes",
            {30'd0, memBus.MemRead, memBus.MemWrite}, 0);
      check("rst MemIn", 32'(memBus.MemIn), 0);
      check("rst WriteData", 32'(memBus.WriteData), 0);
      repeat (2) begin
        @(negedge clock);
        if (done) nDone++;
      end
      reset = 1'b0;
      repeat (4) begin
        @(negedge clock);
        if (done) nDone++;
        if (busy) nBusy++;
      end
      check("rst no done", nDone, 0);
      check("rst stays idle", nBusy, 0);
      modelCopy(16'h0050, 16'h0060, 1, 1'b0, 16'h0);
      checkMem("rst mem");
    end

    doCopy("post_rst", 16'h0070, 16'h0090, 8'd3, 1'b0, 16'h0, 0,
           10, 3, 3, 1'b0);

`ifdef MEM_COPY_FILL_EN
    doCopy("fill", 16'h0000, 16'h0080, 8'd5, 1'b1, 16'hBEEF, 0,
           6, 0, 5, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("fill word", 32'(memArr[8'h80 + 8'(i)]), 32'hBEEF);
    end
`else
    doCopy("fill_ignored", 16'h0030, 16'h0080, 8'd5, 1'b1,
           16'hBEEF, 0, 16, 5, 5, 1'b0);
`endif

    for (int r = 0; r < 25; r++) begin
      logic [15:0] s, d, fv;
      logic [7:0]  n;
      logic        f, fx;
      int          ec, er;
      s  = 16'($urandom);
      d  = 16'($urandom);
      fv = 16'($urandom);
      n  = 8'($urandom_range(0, 10));
      f  = 1'($urandom_range(0, 1));
      fx = f & fe;
      if (n == 0) begin
        ec = 1; er = 0;
      end else if (fx) begin
        ec = int'(n) + 1; er = 0;
      end else begin
        ec = 3 * int'(n) + 1; er = int'(n);
      end
      doCopy("rand", s, d, n, f, fv, 0, ec, er, int'(n), fx);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
